load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 45 ++++
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (11 behaves as a word access)
//   - FSM state enum
//   - default access timeout
package lsu_pkg;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    localparam int unsigned TimeoutDefault = 255;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10
    } lsu_state_e;

    // Fold the reserved encoding 11 onto a word access.
    function automatic logic [1:0] normalize_size(input logic [1:0] size);
        return (size == 2'b11) ? SizeWord : size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the load/store unit.
// Ports:
//   addr_lo       in   low two address bits of the access
//   size          in   normalized access size (byte/half/word)
//   load_unsigned in   1 = zero-extend load data, 0 = sign-extend
//   store_data    in   raw store operand (rs2)
//   rdata         in   raw memory read word
//   be            out  byte enables for the access
//   wdata         out  store data replicated across the word
//   load_data     out  extracted and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
        if (size == SizeByte) begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = load_unsigned ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
        end else if (size == SizeHalf) begin
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata     = {2{store_data[15:0]}};
            load_data = load_unsigned ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between execute and the data bus.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   valid_in, load_in,
//   store_in, addr_in,
//   store_data_in,
//   load_size_in,
//   load_unsigned_in,
//   rd_addr_in                memory operation from execute
//   busy_out                  stall request to upstream pipeline registers
//   dmem_*_out                request, write strobe, word address, data, byte enables
//   dmem_gnt_in, dmem_rvalid_in, dmem_err_in, dmem_rdata_in   bus response
//   load_data_out, load_valid_out, rd_addr_out                writeback result
//   misaligned_out, access_fault_out                          one-cycle exception pulses
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,
    output logic        busy_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_be_out,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic        dmem_err_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic [4:0]  rd_addr_out,
    output logic        misaligned_out,
    output logic        access_fault_out
);

    lsu_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [1:0]  size_q, size_d;
    logic        is_load_q, is_load_d;
    logic        unsigned_q, unsigned_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        misaligned_q, misaligned_d;
    logic        fault_q, fault_d;

    logic        is_mem, misaligned, timeout_hit, in_req;
    logic [1:0]  size_in_n;
    logic [3:0]  be;
    logic [31:0] wdata, load_ext;

    assign size_in_n   = normalize_size(load_size_in);
    assign is_mem      = valid_in & (load_in | store_in);
    assign misaligned  = ((size_in_n == SizeHalf) & addr_in[0]) |
                         ((size_in_n == SizeWord) & (addr_in[1:0] != 2'b00));
    // Counter value of the last cycle allowed before the access is abandoned.
    assign timeout_hit = (cnt_q >= 32'(TIMEOUT - 1));
    assign in_req      = (state_q == StReq);

    lsu_align u_align (
        .addr_lo       (addr_q[1:0]),
        .size          (size_q),
        .load_unsigned (unsigned_q),
        .store_data    (sdata_q),
        .rdata         (dmem_rdata_in),
        .be            (be),
        .wdata         (wdata),
        .load_data     (load_ext)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        size_d       = size_q;
        is_load_d    = is_load_q;
        unsigned_d   = unsigned_q;
        rd_d         = rd_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        rd_out_d     = rd_out_q;
        misaligned_d = 1'b0;
        fault_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mem) begin
                    if (misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d     = addr_in;
                        sdata_d    = store_data_in;
                        size_d     = size_in_n;
                        is_load_d  = load_in;  // load wins when both are set
                        unsigned_d = load_unsigned_in;
                        rd_d       = rd_addr_in;
                        cnt_d      = 32'd0;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 32'd1;
                if (dmem_gnt_in) begin
                    state_d = is_load_q ? StWait : StIdle;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 32'd1;
                if (dmem_rvalid_in) begin
                    if (dmem_err_in) begin
                        fault_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b1;
                        load_data_d  = load_ext;
                        rd_out_d     = rd_q;
                    end
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            cnt_q        <= 32'd0;
            addr_q       <= 32'd0;
            sdata_q      <= 32'd0;
            size_q       <= SizeByte;
            is_load_q    <= 1'b0;
            unsigned_q   <= 1'b0;
            rd_q         <= 5'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            rd_out_q     <= 5'd0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            size_q       <= size_d;
            is_load_q    <= is_load_d;
            unsigned_q   <= unsigned_d;
            rd_q         <= rd_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            rd_out_q     <= rd_out_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    // Bus fields are driven only while requesting so idle and reset show zeros.
    assign dmem_req_out     = in_req;
    assign dmem_we_out      = in_req & ~is_load_q;
    assign dmem_addr_out    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_out   = in_req ? wdata : 32'd0;
    assign dmem_be_out      = in_req ? be : 4'd0;
    // Gated by reset so the stall request is also 0 while reset is held.
    assign busy_out         = rst_in & ((state_q != StIdle) | (is_mem & ~misaligned));
    assign load_data_out    = load_data_q;
    assign load_valid_out   = load_valid_q;
    assign rd_addr_out      = rd_out_q;
    assign misaligned_out   = misaligned_q;
    assign access_fault_out = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in, load_in, store_in, load_unsigned_in;
    logic [31:0] addr_in, store_data_in, dmem_rdata_in;
    logic [1:0]  load_size_in;
    logic [4:0]  rd_addr_in;
    logic        busy_out, dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out, load_data_out;
    logic [3:0]  dmem_be_out;
    logic        dmem_gnt_in, dmem_rvalid_in, dmem_err_in;
    logic        load_valid_out, misaligned_out, access_fault_out;
    logic [4:0]  rd_addr_out;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .valid_in         (valid_in),
        .load_in          (load_in),
        .store_in         (store_in),
        .addr_in          (addr_in),
        .store_data_in    (store_data_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .rd_addr_in       (rd_addr_in),
        .busy_out         (busy_out),
        .dmem_req_out     (dmem_req_out),
        .dmem_we_out      (dmem_we_out),
        .dmem_addr_out    (dmem_addr_out),
        .dmem_wdata_out   (dmem_wdata_out),
        .dmem_be_out      (dmem_be_out),
        .dmem_gnt_in      (dmem_gnt_in),
        .dmem_rvalid_in   (dmem_rvalid_in),
        .dmem_err_in      (dmem_err_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .load_data_out    (load_data_out),
        .load_valid_out   (load_valid_out),
        .rd_addr_out      (rd_addr_out),
        .misaligned_out   (misaligned_out),
        .access_fault_out (access_fault_out)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{busy_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
                 dmem_be_out, load_data_out, load_valid_out, rd_addr_out,
                 misaligned_out, access_fault_out};
    endfunction

    // Reference model: access behaviour from byte counts and offsets.
    function automatic void model(input logic [1:0] sz, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [31:0] rdata,
                                  input logic uns, output logic mis, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int nbytes, off;
        logic [31:0] v, mask;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off    = int'(addr[1:0]);
        mis    = (off % nbytes) != 0;
        be     = 4'(((1 << nbytes) - 1) << off);
        for (int k = 0; k < 4; k++) wd[8*k +: 8] = data[8*(k % nbytes) +: 8];
        v    = rdata >> (8 * off);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nbytes)) - 1);
        v    = v & mask;
        if (!uns && v[8*nbytes-1]) v = v | ~mask;
        ld = v;
    endfunction

    task automatic run_txn(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] data, input logic uns,
                           input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                           input logic err, input logic [31:0] rdata, input logic exp_mis,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_ld);
        int t, j;
        bit granted, completed, timed_out, exp_lv, exp_fault;
        @(posedge clk_in); #1;
        valid_in = 1; load_in = ld; store_in = st; addr_in = addr; store_data_in = data;
        load_size_in = sz; load_unsigned_in = uns; rd_addr_in = rd;
        @(negedge clk_in);
        check({nm, " busy_accept"}, 32'(busy_out), 32'(!exp_mis));
        @(posedge clk_in); #1;
        valid_in = 0;
        if (exp_mis) begin
            @(negedge clk_in);
            check({nm, " misaligned"}, 32'(misaligned_out), 32'd1);
            check({nm, " mis_no_req"}, 32'({dmem_req_out, busy_out}), 32'd0);
            @(posedge clk_in); #1;
            @(negedge clk_in);
            check({nm, " mis_pulse_end"}, 32'({misaligned_out, dmem_req_out}), 32'd0);
            return;
        end
        t = 0; granted = 0; completed = 0; timed_out = 0;
        while (!granted && !timed_out) begin
            dmem_gnt_in = (t == gnt_dly);
            @(negedge clk_in);
            check({nm, " req"}, 32'({dmem_req_out, busy_out}), 32'd3);
            check({nm, " addr"}, dmem_addr_out, addr & ~32'd3);
            check({nm, " be"}, 32'(dmem_be_out), 32'(exp_be));
            check({nm, " we"}, 32'(dmem_we_out), 32'(st && !ld));
            if (st && !ld) check({nm, " wdata"}, dmem_wdata_out, exp_wd);
            if (dmem_gnt_in) granted = 1;
            else if (t >= TO - 1) timed_out = 1;
            t++;
            @(posedge clk_in); #1;
            dmem_gnt_in = 0;
        end
        if (granted && !ld) completed = 1;
        j = 0;
        while (granted && ld && !completed && !timed_out) begin
            dmem_rvalid_in = (j == rv_dly);
            dmem_rdata_in  = dmem_rvalid_in ? rdata : $urandom;
            dmem_err_in    = dmem_rvalid_in ? err : 1'($urandom);
            @(negedge clk_in);
            check({nm, " wait"}, 32'({dmem_req_out, busy_out, load_valid_out}), 32'd2);
            if (dmem_rvalid_in) completed = 1;
            else if (t >= TO - 1) timed_out = 1;
            t++; j++;
            @(posedge clk_in); #1;
            dmem_rvalid_in = 0; dmem_err_in = 0;
        end
        exp_lv    = ld && completed && !err;
        exp_fault = timed_out || (ld && completed && err);
        @(negedge clk_in);
        check({nm, " load_valid"}, 32'(load_valid_out), 32'(exp_lv));
        check({nm, " fault"}, 32'(access_fault_out), 32'(exp_fault));
        check({nm, " idle"}, 32'({dmem_req_out, busy_out}), 32'd0);
        if (exp_lv) begin
            check({nm, " load_data"}, load_data_out, exp_ld);
            check({nm, " rd"}, 32'(rd_addr_out), 32'(rd));
        end
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check({nm, " pulse_end"}, 32'({load_valid_out, access_fault_out}), 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic        ld, st;
        logic [1:0]  sz;
        logic [31:0] addr, data, rdata;
        logic        uns, mis;
        logic [3:0]  be;
        logic [31:0] wd, ldv;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        m;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld, a, d, r;
        logic [1:0]  sz;
        logic        ld, st, uns, err;

        vecs[0]  = '{"sb_103",  0, 1, 2'd0, 32'h103, 32'hAB, 0, 0, 0, 4'b1000, 32'hABABABAB, 0};
        vecs[1]  = '{"lb_102s", 1, 0, 2'd0, 32'h102, 0, 32'h80FF0000, 0, 0, 4'b0100, 0, 32'hFFFFFFFF};
        vecs[2]  = '{"lb_102u", 1, 0, 2'd0, 32'h102, 0, 32'h80FF0000, 1, 0, 4'b0100, 0, 32'h000000FF};
        vecs[3]  = '{"lw_102",  1, 0, 2'd2, 32'h102, 0, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{"sh_202",  0, 1, 2'd1, 32'h202, 32'h12345678, 0, 0, 0, 4'b1100, 32'h56785678, 0};
        vecs[5]  = '{"lh_206s", 1, 0, 2'd1, 32'h206, 0, 32'h80017FFF, 0, 0, 4'b1100, 0, 32'hFFFF8001};
        vecs[6]  = '{"lhu_204", 1, 0, 2'd1, 32'h204, 0, 32'h80017FFF, 1, 0, 4'b0011, 0, 32'h00007FFF};
        vecs[7]  = '{"sw_300",  0, 1, 2'd2, 32'h300, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 0};
        vecs[8]  = '{"l11_304", 1, 0, 2'd3, 32'h304, 0, 32'hCAFEBABE, 0, 0, 4'b1111, 0, 32'hCAFEBABE};
        vecs[9]  = '{"lh_101",  1, 0, 2'd1, 32'h101, 0, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{"ldst_400", 1, 1, 2'd2, 32'h400, 32'h55, 32'h12345678, 0, 0, 4'b1111, 0, 32'h12345678};
        vecs[11] = '{"lbu_101", 1, 0, 2'd0, 32'h101, 0, 32'h00009A00, 1, 0, 4'b0010, 0, 32'h0000009A};
        vecs[12] = '{"s11_401", 0, 1, 2'd3, 32'h401, 32'h1, 0, 0, 1, 0, 0, 0};

        // Reset state, with an aligned load presented to show busy is held low.
        rst_in = 0; valid_in = 1; load_in = 1; store_in = 0; addr_in = 32'h100;
        store_data_in = 0; load_size_in = 2'd2; load_unsigned_in = 0; rd_addr_in = 5'd1;
        dmem_gnt_in = 0; dmem_rvalid_in = 0; dmem_err_in = 0; dmem_rdata_in = 0;
        repeat (3) @(posedge clk_in);
        #2;
        check("reset_outputs", 32'(any_out()), 32'd0);
        valid_in = 0;
        @(posedge clk_in); #1;
        rst_in = 1;
        @(negedge clk_in);
        check("post_reset_idle", 32'(any_out()), 32'd0);

        // Table-driven: grant and rvalid in the earliest cycle (minimum latency).
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].nm, vecs[i].ld, vecs[i].st, vecs[i].sz, vecs[i].addr, vecs[i].data,
                    vecs[i].uns, 5'(i + 3), 0, 0, 1'b0, vecs[i].rdata, vecs[i].mis,
                    vecs[i].be, vecs[i].wd, vecs[i].ldv);
        end

        // Grant never arrives: fault TIMEOUT cycles after the request starts.
        run_txn("lh_timeout", 1, 0, 2'd1, 32'h200, 0, 0, 5'd9, 1000, 0, 1'b0, 0,
                0, 4'b0011, 0, 0);
        // Granted load with a bus error.
        run_txn("lw_err", 1, 0, 2'd2, 32'h500, 0, 0, 5'd10, 1, 1, 1'b1, 32'h11111111,
                0, 4'b1111, 0, 32'h11111111);

        // Reset while waiting for read data; late rvalid must be ignored.
        @(posedge clk_in); #1;
        valid_in = 1; load_in = 1; store_in = 0; addr_in = 32'h600; load_size_in = 2'd2;
        rd_addr_in = 5'd7;
        @(posedge clk_in); #1;
        valid_in = 0; dmem_gnt_in = 1;
        @(posedge clk_in); #1;
        dmem_gnt_in = 0;
        @(negedge clk_in);
        check("rst_wait_busy", 32'({busy_out, dmem_req_out}), 32'd2);
        #2 rst_in = 0;
        #1 check("rst_async_outputs", 32'(any_out()), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1; dmem_rvalid_in = 1; dmem_rdata_in = 32'hFACEFACE;
        @(posedge clk_in); #1;
        dmem_rvalid_in = 0;
        @(negedge clk_in);
        check("rst_late_rvalid", 32'(any_out()), 32'd0);

        // valid_in while a store is still requesting is ignored.
        @(posedge clk_in); #1;
        valid_in = 1; load_in = 0; store_in = 1; addr_in = 32'h700; load_size_in = 2'd2;
        store_data_in = 32'h01020304;
        @(posedge clk_in); #1;
        load_in = 1; store_in = 0; addr_in = 32'h800;
        @(posedge clk_in); #1;
        dmem_gnt_in = 1;
        @(negedge clk_in);
        check("ignore_addr_held", dmem_addr_out, 32'h700);
        check("ignore_we_held", 32'(dmem_we_out), 32'd1);
        @(posedge clk_in); #1;
        dmem_gnt_in = 0; valid_in = 0;
        @(negedge clk_in);
        check("ignore_no_second", 32'({dmem_req_out, busy_out}), 32'd0);

        // Randomized accesses against the model.
        for (int i = 0; i < 60; i++) begin
            ld  = 1'($urandom_range(0, 1));
            st  = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            sz  = 2'($urandom_range(0, 3));
            a   = $urandom; d = $urandom; r = $urandom;
            uns = 1'($urandom_range(0, 1));
            err = ($urandom_range(0, 5) == 0);
            model(sz, a, d, r, uns, m, e_be, e_wd, e_ld);
            run_txn($sformatf("rnd%0d", i), ld, st, sz, a, d, uns, 5'($urandom),
                    $urandom_range(0, TO), $urandom_range(0, 3), err, r, m, e_be, e_wd, e_ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
